mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM between the CPU instruction-fetch port and data port, for a unified-memory build of the DLX system.
- Arbitrates each cycle and drives the RAM control, address and write-data signals from the winning requester.
- Tags each read so the 1-cycle-late RAM data is steered to the correct requester.
- Contains a starvation guard so fetch cannot be locked out by back-to-back data accesses.

Parameters:
- ADDR_W, 13, byte address width (RAM word address bits + 2).
- DATA_W, 32, data width.
- STARVE_MAX, 3, consecutive lost contentions after which the instruction port is forced to win (range 1..15).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- i_req_i  in  1  instruction read request.
- i_addr_i  in  ADDR_W  instruction byte address.
- i_gnt_o  out  1  instruction request accepted this cycle.
- i_rvalid_o  out  1  instruction read data valid on i_rdata_o.
- i_rdata_o  out  DATA_W  instruction read data.
- d_req_i  in  1  data request.
- d_we_i  in  1  1 = write, 0 = read.
- d_addr_i  in  ADDR_W  data byte address.
- d_wdata_i  in  DATA_W  write data.
- d_format_i  in  2  access size, encoded as the data_memory data_format code.
- d_sign_i  in  1  sign-extend on load.
- d_gnt_o  out  1  data request accepted this cycle.
- d_rvalid_o  out  1  data read data valid on d_rdata_o.
- d_rdata_o  out  DATA_W  data read data.
- mem_en_o  out  1  RAM enable.
- mem_we_o  out  1  RAM write enable.
- mem_addr_o  out  ADDR_W  RAM address.
- mem_din_o  out  DATA_W  RAM write data.
- mem_format_o  out  2  RAM data format.
- mem_sign_o  out  1  RAM sign control.
- mem_dout_i  in  DATA_W  RAM read data, valid 1 cycle after an enabled read.

Behaviour:
- Grant logic is combinational within the request cycle. At most one of i_gnt_o/d_gnt_o is high in any cycle.
- Requesters hold req and all attributes stable until their gnt is sampled high. Dropping req before grant is legal and cancels the request with no side effects.
- Default priority: data over instruction.
- starve_cnt (4 bits):
  - increments each cycle both ports request and data wins;
  - clears whenever the instruction port is granted or i_req_i is low;
  - saturates at STARVE_MAX.
  - When starve_cnt == STARVE_MAX and both ports request, instruction wins.
- RAM mux:
  - mem_en_o = i_gnt_o | d_gnt_o.
  - On an instruction grant: mem_we_o = 0, mem_format_o = FMT_WORD, mem_sign_o = 0, mem_din_o = 0.
  - On a data grant: all mem_* signals come from the d_* inputs.
  - With no grant: all mem_* outputs are 0.
- Read tag rd_owner (NONE/INSTR/DATA):
  - registered each cycle from the grant of a read.
  - Data writes set rd_owner to NONE; a write completes in its grant cycle and returns no rvalid.
  - i_rvalid_o = (rd_owner == INSTR); d_rvalid_o = (rd_owner == DATA).
  - i_rdata_o and d_rdata_o both carry mem_dout_i; only the matching rvalid qualifies the data.
- Throughput: one access per cycle. A grant in cycle N gives rvalid in cycle N+1, and a new grant is allowed in N+1 (pipelined).
- Reset:
  - While rst_i is high, all gnt, rvalid and mem_* outputs are 0.
  - rd_owner <= NONE and starve_cnt <= 0.
  - Reset asserted in the cycle after a grant suppresses that rvalid; the read is lost and the requester re-issues.
- Boundary cases:
  - A single requester is always granted immediately.
  - When starve_cnt is saturated and only d_req_i is high, data is granted and starve_cnt stays saturated only while i_req_i is high.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: on contention the winner alternates using a last_winner flop (reset to INSTR, so the first contention goes to data). starve_cnt logic is compiled out.
- Undefined: fixed data priority with the starvation guard as above.

Decomposition:
- Shared package mem_arb_pkg holds:
  - owner_t enum {OWN_NONE = 2'b00, OWN_INSTR = 2'b01, OWN_DATA = 2'b10};
  - FMT_WORD = 2'b10, FMT_HALF = 2'b01, FMT_BYTE = 2'b00;
  - default ADDR_W/DATA_W.
- One natural sub-module, arb_grant_2: two-way grant selection covering fixed priority with starve counter, or round-robin under the macro.
- The mux and rd_owner pipeline stay in the top module.

Test Plan:
- i_req_i only, i_addr_i = 0x010, RAM word 4 = 0xDEADBEEF → i_gnt_o = 1 in the same cycle; next cycle i_rvalid_o = 1, i_rdata_o = 0xDEADBEEF, d_rvalid_o = 0.
- Both request in one cycle, d_we_i = 0, d_addr_i = 0x020 → d_gnt_o = 1, i_gnt_o = 0, mem_addr_o = 0x020; next cycle d_rvalid_o = 1.
- Both held requesting for 5 cycles (data re-requests each cycle), STARVE_MAX = 3 → data wins cycles 0-2, instruction wins cycle 3, data wins cycle 4.
- Data write d_addr_i = 0x040, d_wdata_i = 0x12345678, d_format_i = FMT_WORD → mem_we_o = 1 in the grant cycle, no rvalid next cycle; a following instruction read of 0x040 returns 0x12345678.
- Instruction granted in cycle N, rst_i high in N+1 → i_rvalid_o = 0 in N+1, mem_en_o = 0, and starve_cnt = 0 after reset.
- With ARB_ROUND_ROBIN_EN, both requesting continuously for 4 cycles → grants D, I, D, I.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the unified-memory port arbiter
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 13;
  localparam int DEF_DATA_W = 32;

  localparam logic [1:0] FMT_BYTE = 2'b00;
  localparam logic [1:0] FMT_HALF = 2'b01;
  localparam logic [1:0] FMT_WORD = 2'b10;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'b00,
    OWN_INSTR = 2'b01,
    OWN_DATA  = 2'b10
  } owner_t;

endpackage

// File: rtl/arb_grant_2.sv
// rtl/arb_grant_2.sv - two-way grant: data priority with fetch starvation guard, or round robin (ARB_ROUND_ROBIN_EN)
module arb_grant_2 #(
  parameter int STARVE_MAX = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_ireq,
  input  logic i_dreq,
  output logic o_igrant,
  output logic o_dgrant
);

  logic w_contend;
  assign w_contend = i_ireq & i_dreq;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = instruction port won the most recent grant.
  logic r_last_instr;

  always_comb begin
    o_igrant = w_contend ? ~r_last_instr : i_ireq;
    o_dgrant = i_dreq & ~o_igrant;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_instr <= 1'b1;
    end else if (o_igrant) begin
      r_last_instr <= 1'b1;
    end else if (o_dgrant) begin
      r_last_instr <= 1'b0;
    end
  end
`else
  logic [3:0] r_starve_cnt;
  logic       w_force_i;

  assign w_force_i = w_contend & (r_starve_cnt == 4'(STARVE_MAX));

  always_comb begin
    o_igrant = i_ireq & (~i_dreq | w_force_i);
    o_dgrant = i_dreq & ~o_igrant;
  end

  // Counts consecutive contentions lost by fetch; saturates so the force stays armed.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_starve_cnt <= 4'd0;
    end else if (o_igrant | ~i_ireq) begin
      r_starve_cnt <= 4'd0;
    end else if (r_starve_cnt != 4'(STARVE_MAX)) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one sync RAM between fetch and data ports; ARB_ROUND_ROBIN_EN selects round robin
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_gnt_o,
  output logic              i_rvalid_o,
  output logic [DATA_W-1:0] i_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  input  logic [1:0]        d_format_i,
  input  logic              d_sign_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_din_o,
  output logic [1:0]        mem_format_o,
  output logic              mem_sign_o,
  input  logic [DATA_W-1:0] mem_dout_i
);

  logic   w_i_req;
  logic   w_d_req;
  owner_t r_rd_owner;

  // Masking requests during reset keeps every grant and mem_* output low.
  assign w_i_req = i_req_i & ~rst_i;
  assign w_d_req = d_req_i & ~rst_i;

  arb_grant_2 #(
    .STARVE_MAX(STARVE_MAX)
  ) u_grant (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_ireq  (w_i_req),
    .i_dreq  (w_d_req),
    .o_igrant(i_gnt_o),
    .o_dgrant(d_gnt_o)
  );

  always_comb begin
    mem_en_o     = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_din_o    = '0;
    mem_format_o = 2'b00;
    mem_sign_o   = 1'b0;
    if (i_gnt_o) begin
      mem_en_o     = 1'b1;
      mem_addr_o   = i_addr_i;
      mem_format_o = FMT_WORD;
    end else if (d_gnt_o) begin
      mem_en_o     = 1'b1;
      mem_we_o     = d_we_i;
      mem_addr_o   = d_addr_i;
      mem_din_o    = d_wdata_i;
      mem_format_o = d_format_i;
      mem_sign_o   = d_sign_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_owner <= OWN_NONE;
    end else if (i_gnt_o) begin
      r_rd_owner <= OWN_INSTR;
    end else if (d_gnt_o & ~d_we_i) begin
      r_rd_owner <= OWN_DATA;
    end else begin
      r_rd_owner <= OWN_NONE;
    end
  end

  // A reset in the cycle after a grant drops that read's rvalid.
  assign i_rvalid_o = (r_rd_owner == OWN_INSTR) & ~rst_i;
  assign d_rvalid_o = (r_rd_owner == OWN_DATA) & ~rst_i;
  assign i_rdata_o  = mem_dout_i;
  assign d_rdata_o  = mem_dout_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int AW = 13;
  localparam int DW = 32;
  localparam int SMAX = 3;
  localparam int NWORDS = 2048;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, d_req, d_we, d_sign;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic [1:0]    d_fmt;
  logic          i_gnt, i_rvalid, d_gnt, d_rvalid;
  logic [DW-1:0] i_rdata, d_rdata;
  logic          mem_en, mem_we, mem_sign;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;
  logic [1:0]    mem_fmt;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ram   [NWORDS];
  logic [DW-1:0] model [NWORDS];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk_i(clk), .rst_i(rst),
    .i_req_i(i_req), .i_addr_i(i_addr), .i_gnt_o(i_gnt),
    .i_rvalid_o(i_rvalid), .i_rdata_o(i_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_format_i(d_fmt), .d_sign_i(d_sign), .d_gnt_o(d_gnt),
    .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_din_o(mem_din), .mem_format_o(mem_fmt), .mem_sign_o(mem_sign),
    .mem_dout_i(mem_dout)
  );

  // Single-port synchronous RAM, word addressed, one cycle read latency.
  always_ff @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[AW-1:2]] <= mem_din;
      else        mem_dout <= ram[mem_addr[AW-1:2]];
    end
  end

  function automatic logic [DW-1:0] init_val(int k);
    if (k == 4) return 32'hDEADBEEF;
    return 32'h5A00_0000 ^ (k * 32'h0001_0203);
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [AW-1:0] ia, input logic dr, input logic dwe,
                       input logic [AW-1:0] da, input logic [DW-1:0] dwd, input logic [1:0] df,
                       input logic ds);
    i_req = ir; i_addr = ia; d_req = dr; d_we = dwe;
    d_addr = da; d_wdata = dwd; d_fmt = df; d_sign = ds;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    string         nm;
    logic          ir; logic [AW-1:0] ia;
    logic          dr; logic dwe; logic [AW-1:0] da; logic [DW-1:0] dwd;
    logic [1:0]    df; logic ds;
    logic          e_ig, e_dg, e_we; logic [AW-1:0] e_addr; logic [DW-1:0] e_din;
    logic [1:0]    e_fmt; logic e_sg; logic e_irv, e_drv; logic [DW-1:0] e_rd;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic exp_i_seq [5];
    logic exp_i_rst [4];
    int   starve, pend;
    logic last_i;
    logic [DW-1:0] pend_data;
    logic ir, dr, win_i, win_d, both;

    for (int k = 0; k < NWORDS; k++) begin
      ram[k]   = init_val(k);
      model[k] = init_val(k);
    end
    mem_dout = '0;

    // name, inputs..., expected: ig dg we addr din fmt sign irv drv rdata
    vecs[0] = '{"none", 0, 13'h000, 0, 0, 13'h000, 32'h0, 2'b00, 0,
                0, 0, 0, 13'h000, 32'h0, 2'b00, 0, 0, 0, 32'h0};
    vecs[1] = '{"i_only", 1, 13'h0A4, 0, 0, 13'h000, 32'h0, 2'b00, 0,
                1, 0, 0, 13'h0A4, 32'h0, 2'b10, 0, 1, 0, init_val(13'h0A4 >> 2)};
    vecs[2] = '{"d_read_half", 0, 13'h000, 1, 0, 13'h033, 32'hCAFEF00D, 2'b01, 1,
                0, 1, 0, 13'h033, 32'hCAFEF00D, 2'b01, 1, 0, 1, init_val(13'h033 >> 2)};
    vecs[3] = '{"i_with_d_noise", 1, 13'h1C8, 0, 1, 13'h0FF, 32'hFFFFFFFF, 2'b01, 1,
                1, 0, 0, 13'h1C8, 32'h0, 2'b10, 0, 1, 0, init_val(13'h1C8 >> 2)};
    vecs[4] = '{"d_write_byte", 0, 13'h000, 1, 1, 13'h1F0, 32'h0BADF00D, 2'b00, 0,
                0, 1, 1, 13'h1F0, 32'h0BADF00D, 2'b00, 0, 0, 0, 32'h0};
    vecs[5] = '{"both_d_write", 1, 13'h008, 1, 1, 13'h1E0, 32'h11223344, 2'b10, 0,
                0, 1, 1, 13'h1E0, 32'h11223344, 2'b10, 0, 0, 0, 32'h0};

`ifdef ARB_ROUND_ROBIN_EN
    exp_i_seq = '{0, 1, 0, 1, 0};
    exp_i_rst = '{0, 1, 0, 1};
`else
    exp_i_seq = '{0, 0, 0, 1, 0};
    exp_i_rst = '{0, 0, 0, 1};
`endif

    rst = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    drive(1'b1, 13'h010, 1'b1, 1'b0, 13'h020, 32'h0, 2'b10, 1'b0);
    #2;
    chk("rst_i_gnt", {31'b0, i_gnt}, 32'd0);
    chk("rst_d_gnt", {31'b0, d_gnt}, 32'd0);
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst_mem_addr", {19'b0, mem_addr}, 32'd0);
    chk("rst_rvalid", {30'b0, i_rvalid, d_rvalid}, 32'd0);
    @(negedge clk);

    foreach (vecs[n]) begin
      do_reset();
      drive(vecs[n].ir, vecs[n].ia, vecs[n].dr, vecs[n].dwe, vecs[n].da, vecs[n].dwd,
            vecs[n].df, vecs[n].ds);
      #2;
      chk({vecs[n].nm, "_i_gnt"}, {31'b0, i_gnt}, {31'b0, vecs[n].e_ig});
      chk({vecs[n].nm, "_d_gnt"}, {31'b0, d_gnt}, {31'b0, vecs[n].e_dg});
      chk({vecs[n].nm, "_mem_en"}, {31'b0, mem_en}, {31'b0, vecs[n].e_ig | vecs[n].e_dg});
      chk({vecs[n].nm, "_mem_we"}, {31'b0, mem_we}, {31'b0, vecs[n].e_we});
      chk({vecs[n].nm, "_mem_addr"}, {19'b0, mem_addr}, {19'b0, vecs[n].e_addr});
      chk({vecs[n].nm, "_mem_din"}, mem_din, vecs[n].e_din);
      chk({vecs[n].nm, "_mem_fmt"}, {30'b0, mem_fmt}, {30'b0, vecs[n].e_fmt});
      chk({vecs[n].nm, "_mem_sign"}, {31'b0, mem_sign}, {31'b0, vecs[n].e_sg});
      @(negedge clk);
      idle();
      #2;
      chk({vecs[n].nm, "_i_rvalid"}, {31'b0, i_rvalid}, {31'b0, vecs[n].e_irv});
      chk({vecs[n].nm, "_d_rvalid"}, {31'b0, d_rvalid}, {31'b0, vecs[n].e_drv});
      if (vecs[n].e_irv) chk({vecs[n].nm, "_i_rdata"}, i_rdata, vecs[n].e_rd);
      if (vecs[n].e_drv) chk({vecs[n].nm, "_d_rdata"}, d_rdata, vecs[n].e_rd);
      @(negedge clk);
    end

    // Fetch of word 4 and data read under contention.
    do_reset();
    drive(1'b1, 13'h010, 1'b0, 1'b0, '0, '0, 2'b10, 1'b0);
    #2;
    chk("seq_fetch_gnt", {31'b0, i_gnt}, 32'd1);
    @(negedge clk);
    drive(1'b1, 13'h014, 1'b1, 1'b0, 13'h020, 32'h0, 2'b10, 1'b0);
    #2;
    chk("seq_fetch_rvalid", {31'b0, i_rvalid}, 32'd1);
    chk("seq_fetch_rdata", i_rdata, 32'hDEADBEEF);
    chk("seq_fetch_d_rvalid", {31'b0, d_rvalid}, 32'd0);
    chk("seq_cont_d_gnt", {30'b0, d_gnt, i_gnt}, 32'd2);
    chk("seq_cont_addr", {19'b0, mem_addr}, 32'h020);
    @(negedge clk);
    idle();
    #2;
    chk("seq_cont_d_rvalid", {31'b0, d_rvalid}, 32'd1);
    chk("seq_cont_d_rdata", d_rdata, init_val(8));
    @(negedge clk);

    // Five cycles of continuous contention from a clean state.
    do_reset();
    drive(1'b1, 13'h100, 1'b1, 1'b0, 13'h104, 32'h0, 2'b10, 1'b0);
    for (int c = 0; c < 5; c++) begin
      #2;
      chk($sformatf("starve_c%0d_i_gnt", c), {31'b0, i_gnt}, {31'b0, exp_i_seq[c]});
      chk($sformatf("starve_c%0d_d_gnt", c), {31'b0, d_gnt}, {31'b0, ~exp_i_seq[c]});
      @(negedge clk);
    end

    // Word write then fetch of the same address.
    do_reset();
    drive(1'b0, '0, 1'b1, 1'b1, 13'h040, 32'h12345678, 2'b10, 1'b0);
    #2;
    chk("wr_mem_we", {30'b0, mem_we, mem_en}, 32'd3);
    @(negedge clk);
    drive(1'b1, 13'h040, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
    #2;
    chk("wr_no_rvalid", {30'b0, i_rvalid, d_rvalid}, 32'd0);
    chk("wr_fetch_gnt", {31'b0, i_gnt}, 32'd1);
    @(negedge clk);
    idle();
    #2;
    chk("wr_readback", i_rdata, 32'h12345678);
    chk("wr_readback_valid", {31'b0, i_rvalid}, 32'd1);
    @(negedge clk);

    // Reset right after a fetch grant; then contention from a cleared state.
    do_reset();
    drive(1'b1, 13'h010, 1'b1, 1'b0, 13'h024, '0, 2'b10, 1'b0);
    d_req = 1'b0;
    #2;
    chk("rcut_gnt", {31'b0, i_gnt}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    d_req = 1'b1;
    #2;
    chk("rcut_i_rvalid", {31'b0, i_rvalid}, 32'd0);
    chk("rcut_mem_en", {31'b0, mem_en}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #2;
      chk($sformatf("rcut_c%0d_i_gnt", c), {31'b0, i_gnt}, {31'b0, exp_i_rst[c]});
      @(negedge clk);
    end

    // Random traffic in a region untouched above, against a queue-free reference.
    do_reset();
    starve = 0;
    last_i = 1'b1;
    pend = 0;
    pend_data = '0;
    for (int c = 0; c < 600; c++) begin
      ir = ($urandom_range(0, 3) != 0);
      dr = ($urandom_range(0, 3) != 0);
      drive(ir, AW'(13'h200 + 4 * $urandom_range(0, 127)), dr, 1'($urandom),
            AW'(13'h200 + 4 * $urandom_range(0, 127)), $urandom, 2'($urandom), 1'($urandom));
      both = ir & dr;
`ifdef ARB_ROUND_ROBIN_EN
      win_i = both ? ~last_i : ir;
`else
      win_i = both ? (starve == SMAX) : ir;
`endif
      win_d = dr & ~win_i;
      #2;
      chk("rnd_i_gnt", {31'b0, i_gnt}, {31'b0, win_i});
      chk("rnd_d_gnt", {31'b0, d_gnt}, {31'b0, win_d});
      chk("rnd_mem_addr", {19'b0, mem_addr},
          {19'b0, win_i ? i_addr : (win_d ? d_addr : 13'h0)});
      chk("rnd_mem_we", {31'b0, mem_we}, {31'b0, win_d & d_we});
      chk("rnd_i_rvalid", {31'b0, i_rvalid}, {31'b0, pend == 1});
      chk("rnd_d_rvalid", {31'b0, d_rvalid}, {31'b0, pend == 2});
      if (pend != 0) chk("rnd_rdata", i_rdata, pend_data);
      pend = win_i ? 1 : ((win_d && !d_we) ? 2 : 0);
      pend_data = win_i ? model[i_addr[AW-1:2]] : model[d_addr[AW-1:2]];
      if (win_d && d_we) model[d_addr[AW-1:2]] = d_wdata;
      starve = (both && win_d) ? ((starve + 1 > SMAX) ? SMAX : starve + 1) : 0;
      if (win_i) last_i = 1'b1;
      else if (win_d) last_i = 1'b0;
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
